// File: rtl/scp_bus_responder.sv
// scp_bus_responder
// Executes one decoded bus access at a time for the single-cycle processor.
// Memory accesses hit an internal word array after WAIT_STATES extra cycles.
// IO writes go into a small transmit FIFO. IO reads take one word from an
// external input port.
//
// Handshake rules (both IO ports): a word moves on a rising edge only when
// valid and ready are both high during the preceding cycle. A producer
// holds valid and data stable until that edge. Ready may depend
// combinationally on valid (io_in_ready does), never the other way round.
//
// dbg_state exposes the FSM state for checkers:
//   0 = IDLE, 1 = MEM_WAIT, 2 = IO_WAIT, 3 = RESP.
module scp_bus_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              Rd,
   input  logic              Wr,
   input  logic              IOMemSel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              io_out_valid,
   output logic [DATA_W-1:0] io_out_data,
   input  logic              io_out_ready,
   input  logic              io_in_valid,
   input  logic [DATA_W-1:0] io_in_data,
   output logic              io_in_ready,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W     = 4;
   localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int MEM_WORDS = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      IO_WAIT  = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Request fields captured at accept. IOMemSel needs no register of its
   // own: the state the FSM moves to already records memory vs IO.
   logic              lat_rd;
   logic              lat_wr;
   logic              err_q;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fifo_cnt;

   logic accept;
   logic mem_access;
   logic mem_we;
   logic mem_re;
   logic fifo_full;
   logic push;
   logic pop;
   logic io_rd_hs;

   assign accept     = (state_q == IDLE) && req_valid;
   assign mem_access = (state_q == MEM_WAIT) && (cnt_q == '0);
   assign mem_we     = mem_access && lat_wr;
   assign mem_re     = mem_access && lat_rd;
   assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
   // A full FIFO blocks the push even if a pop happens on the same edge;
   // the push simply retries on the next cycle.
   assign push       = (state_q == IO_WAIT) && lat_wr && !fifo_full;
   assign io_rd_hs   = (state_q == IO_WAIT) && lat_rd && io_in_valid;
   assign pop        = io_out_valid && io_out_ready;

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == RESP);
   assign err          = (state_q == RESP) && err_q;
   assign io_in_ready  = io_rd_hs;
   assign io_out_valid = (fifo_cnt != '0);
   assign io_out_data  = fifo_mem[rd_ptr];
   assign dbg_state    = state_q;

   // State and wait-state counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: decode at accept, count wait states, wait on IO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (Rd ^ Wr) begin
                  if (IOMemSel) begin
                     state_d = IO_WAIT;
                  end else begin
                     state_d = MEM_WAIT;
                     cnt_d   = CNT_W'(WAIT_STATES);
                  end
               end else begin
                  state_d = RESP;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = RESP;
            end
         end
         IO_WAIT: begin
            if (push || io_rd_hs) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capture the request fields and the malformed-request flag on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         err_q     <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_rd    <= Rd;
         lat_wr    <= Wr;
         err_q     <= !(Rd ^ Wr);
         lat_addr  <= addr;
         lat_wdata <= wdata;
      end
   end

   // Read data only changes on a memory read access or an IO read handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (mem_re) begin
         rdata <= mem[lat_addr];
      end else if (io_rd_hs) begin
         rdata <= io_in_data;
      end
   end

   // Word array, deliberately not reset. The write enable comes from
   // reset-cleared state, so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[lat_addr] <= lat_wdata;
      end
   end

   // Transmit FIFO: storage, wrapping pointers and occupancy, all cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= lat_wdata;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_scp_bus_responder.sv
// Bench for scp_bus_responder: directed steps followed by a random mix of
// accesses, all checked against a reference model of memory contents,
// read data and transmit order.
module tb_scp_bus_responder;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int WS     = 1;
   localparam int WS3    = 3;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_valid3 = 1'b0;
   logic              rd = 1'b0;
   logic              wr = 1'b0;
   logic              io_sel = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              io_out_ready = 1'b0;
   logic              io_in_valid = 1'b0;
   logic [DATA_W-1:0] io_in_data = '0;

   logic [DATA_W-1:0] rdata, rdata3, io_out_data, io_out_data3;
   logic              busy, done, err, io_out_valid, io_in_ready;
   logic              busy3, done3, err3, io_out_valid3, io_in_ready3;
   logic [1:0]        dbg_state, dbg_state3;

   // Reference model
   logic [DATA_W-1:0] ref_mem [256];
   logic [DATA_W-1:0] ref_rdata = '0;
   logic [DATA_W-1:0] ref_rdata3 = '0;
   logic [DATA_W-1:0] exp_q[$];

   int   checks = 0;
   int   errors = 0;
   logic use3 = 1'b0;
   logic rand_ready = 1'b0;

   logic              m_done, m_busy, m_err;
   logic [DATA_W-1:0] m_rdata;
   assign m_done  = use3 ? done3  : done;
   assign m_busy  = use3 ? busy3  : busy;
   assign m_err   = use3 ? err3   : err;
   assign m_rdata = use3 ? rdata3 : rdata;

   scp_bus_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .Rd(rd), .Wr(wr), .IOMemSel(io_sel),
      .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
      .io_out_valid(io_out_valid), .io_out_data(io_out_data), .io_out_ready(io_out_ready),
      .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_ready(io_in_ready),
      .dbg_state(dbg_state)
   );

   scp_bus_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS3), .FIFO_DEPTH(DEPTH)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .Rd(rd), .Wr(wr), .IOMemSel(io_sel),
      .addr(addr), .wdata(wdata), .rdata(rdata3), .busy(busy3), .done(done3), .err(err3),
      .io_out_valid(io_out_valid3), .io_out_data(io_out_data3), .io_out_ready(io_out_ready),
      .io_in_valid(io_in_valid), .io_in_data(io_in_data), .io_in_ready(io_in_ready3),
      .dbg_state(dbg_state3)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Transmit scoreboard: every pop must deliver the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && io_out_valid && io_out_ready) begin
         chk("tx_q_nonempty", (exp_q.size() != 0), 1'b1);
         if (exp_q.size() != 0) begin
            chk("tx_order", io_out_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) io_out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_req(input logic r, input logic w, input logic s,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rd = r; wr = w; io_sel = s; addr = a; wdata = d;
      if (use3) req_valid3 = 1'b1;
      else      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
      req_valid3 = 1'b0;
   endtask

   // Latency counts the accept edge as 1. exp_lat == 0 means "any bounded latency".
   task automatic run_and_check(input string tag, input logic r, input logic w, input logic s,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input int exp_lat, input logic exp_err, input logic [DATA_W-1:0] exp_rd);
      int   lat;
      logic bz;
      logic e;
      logic [DATA_W-1:0] rdo;
      drive_req(r, w, s, a, d);
      lat = 1;
      bz  = 1'b1;
      while (!m_done && lat < 40) begin
         bz &= m_busy;
         tick();
         lat++;
      end
      if (!m_done) lat = -1;
      e   = m_err;
      rdo = m_rdata;
      bz &= m_busy;
      if (exp_lat == 0) chk({tag, "_lat_bounded"}, (lat > 0), 1'b1);
      else              chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_err"}, e, exp_err);
      chk({tag, "_rdata"}, rdo, exp_rd);
      chk({tag, "_busy"}, bz, 1'b1);
      tick();
      chk({tag, "_pulse_end"}, (!m_done && !m_busy), 1'b1);
   endtask

   task automatic run_io_read(input string tag, input int k, input logic [DATA_W-1:0] d);
      int   lat;
      logic stall_ok;
      logic hs;
      io_in_valid = 1'b0;
      drive_req(1'b1, 1'b0, 1'b1, '0, '0);
      lat = 1;
      stall_ok = 1'b1;
      for (int i = 0; i < k; i++) begin
         stall_ok &= !io_in_ready && !done && busy;
         tick();
         lat++;
      end
      io_in_valid = 1'b1;
      io_in_data  = d;
      #1;
      hs = io_in_ready;
      tick();
      lat++;
      io_in_valid = 1'b0;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      if (!done) lat = -1;
      chk({tag, "_stall"}, stall_ok, 1'b1);
      chk({tag, "_ready"}, hs, 1'b1);
      chk({tag, "_lat"}, lat, 2 + k);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_rdata"}, rdata, d);
      tick();
      chk({tag, "_pulse_end"}, (!done && !busy && !io_in_ready), 1'b1);
   endtask

   task automatic drain();
      int n;
      io_out_ready = 1'b1;
      n = 0;
      while (io_out_valid && n < 20) begin
         tick();
         n++;
      end
      io_out_ready = 1'b0;
      chk("drain_valid_low", io_out_valid, 1'b0);
      chk("drain_q_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic stall_ok;
      int   n;
      logic [DATA_W-1:0] seen;
      logic [DATA_W-1:0] w;
      logic [ADDR_W-1:0] a;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_io_in_ready", io_in_ready, 1'b0);
      chk("rst_io_out_valid", io_out_valid, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_io_out_data", io_out_data, 32'h0);
      chk("rst_state", dbg_state, 2'd0);
      rst_n = 1'b1;
      tick();

      // Memory write then read, WAIT_STATES=1
      run_and_check("mem_wr", 1'b0, 1'b1, 1'b0, 8'h12, 32'hDEADBEEF, WS + 2, 1'b0, ref_rdata);
      ref_rdata = 32'hDEADBEEF;
      run_and_check("mem_rd", 1'b1, 1'b0, 1'b0, 8'h12, 32'h0, WS + 2, 1'b0, ref_rdata);

      // Malformed requests leave rdata and memory alone
      run_and_check("bad_rw", 1'b1, 1'b1, 1'b0, 8'h12, 32'h11111111, 1, 1'b1, ref_rdata);
      run_and_check("bad_none", 1'b0, 1'b0, 1'b1, 8'h12, 32'h22222222, 1, 1'b1, ref_rdata);
      run_and_check("mem_rd_after_bad", 1'b1, 1'b0, 1'b0, 8'h12, 32'h0, WS + 2, 1'b0, ref_rdata);

      // IO write overflow
      io_out_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         w = 32'hC0DE0000 + i;
         exp_q.push_back(w);
         run_and_check("io_wr", 1'b0, 1'b1, 1'b1, 8'h00, w, 2, 1'b0, ref_rdata);
      end
      chk("ovf_valid", io_out_valid, 1'b1);
      chk("ovf_head", io_out_data, 32'hC0DE0001);
      w = 32'hC0DE0005;
      exp_q.push_back(w);
      drive_req(1'b0, 1'b1, 1'b1, 8'h00, w);
      stall_ok = 1'b1;
      repeat (4) begin
         stall_ok &= busy && !done;
         tick();
      end
      chk("ovf_stall", stall_ok, 1'b1);
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
      chk("ovf_blocked_on_pop", done, 1'b0);
      tick();
      chk("ovf_done", done, 1'b1);
      chk("ovf_err", err, 1'b0);
      tick();
      chk("ovf_idle", busy, 1'b0);
      drain();

      // IO read stall then handshake
      run_io_read("io_rd_stall", 5, 32'h0000A5A5);
      ref_rdata = 32'h0000A5A5;

      // req_valid pulse while busy is ignored
      ref_rdata = 32'hDEADBEEF;
      drive_req(1'b1, 1'b0, 1'b0, 8'h12, 32'h0);
      rd = 1'b1; wr = 1'b1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n = 0;
      seen = '0;
      repeat (8) begin
         if (done) begin
            n++;
            seen = rdata;
         end
         tick();
      end
      chk("ignore_done_count", n, 1);
      chk("ignore_rdata", seen, ref_rdata);

      // Reset in MEM_WAIT of a write, WAIT_STATES=3
      use3 = 1'b1;
      run_and_check("m3_wr", 1'b0, 1'b1, 1'b0, 8'h05, 32'h13572468, WS3 + 2, 1'b0, ref_rdata3);
      ref_rdata3 = 32'h13572468;
      run_and_check("m3_rd", 1'b1, 1'b0, 1'b0, 8'h05, 32'h0, WS3 + 2, 1'b0, ref_rdata3);
      drive_req(1'b0, 1'b1, 1'b0, 8'h05, 32'hBADBAD00);
      tick();
      chk("abort_busy_before", busy3, 1'b1);
      rst_n = 1'b0;
      #1;
      ref_rdata3 = '0;
      ref_rdata  = '0;
      exp_q.delete();
      chk("abort_busy", busy3, 1'b0);
      chk("abort_done", done3, 1'b0);
      chk("abort_err", err3, 1'b0);
      chk("abort_rdata", rdata3, ref_rdata3);
      chk("abort_io_in_ready", io_in_ready3, 1'b0);
      chk("abort_io_out_valid", io_out_valid3, 1'b0);
      chk("abort_io_out_data", io_out_data3, 32'h0);
      chk("abort_state", dbg_state3, 2'd0);
      chk("abort_main_rdata", rdata, ref_rdata);
      n = 0;
      repeat (3) begin
         tick();
         if (done3) n++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         if (done3) n++;
      end
      chk("abort_no_done", n, 0);
      ref_rdata3 = 32'h13572468;
      run_and_check("m3_rd_after_abort", 1'b1, 1'b0, 1'b0, 8'h05, 32'h0, WS3 + 2, 1'b0, ref_rdata3);
      use3 = 1'b0;

      // Random mix against the reference model
      rand_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 8'h20 + 8'(i);
         w = $urandom();
         ref_mem[a] = w;
         run_and_check("rnd_init_wr", 1'b0, 1'b1, 1'b0, a, w, WS + 2, 1'b0, ref_rdata);
      end
      for (int i = 0; i < 60; i++) begin
         int op;
         op = $urandom_range(0, 4);
         a  = 8'h20 + 8'($urandom_range(0, 15));
         w  = $urandom();
         case (op)
            0: begin
               ref_mem[a] = w;
               run_and_check("rnd_mem_wr", 1'b0, 1'b1, 1'b0, a, w, WS + 2, 1'b0, ref_rdata);
            end
            1: begin
               ref_rdata = ref_mem[a];
               run_and_check("rnd_mem_rd", 1'b1, 1'b0, 1'b0, a, w, WS + 2, 1'b0, ref_rdata);
            end
            2: begin
               n = (exp_q.size() < DEPTH) ? 2 : 0;
               exp_q.push_back(w);
               run_and_check("rnd_io_wr", 1'b0, 1'b1, 1'b1, a, w, n, 1'b0, ref_rdata);
            end
            3: begin
               run_io_read("rnd_io_rd", $urandom_range(0, 3), w);
               ref_rdata = w;
            end
            default: begin
               logic both;
               both = 1'($urandom_range(0, 1));
               run_and_check("rnd_bad", both, both, 1'($urandom_range(0, 1)), a, w, 1, 1'b1, ref_rdata);
            end
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_ready = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scp_bus_responder.md
# scp_bus_responder

Memory/IO responder for the single-cycle processor's bus. The controller decodes `opCode` into `Rd`, `Wr` and `IOMemSel`; this block executes the resulting access. It serves memory accesses from an internal word array with programmable wait states. IO writes go into a transmit FIFO, and IO reads come from an external valid/ready input port.

## Interface
- `ADDR_W`, 8: memory address width; the memory holds 2^ADDR_W words.
- `DATA_W`, 32: data word width.
- `WAIT_STATES`, 1: extra cycles inserted before every memory access (0..15).
- `FIFO_DEPTH`, 4: IO transmit FIFO depth (power of two, ≥2).

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  access strobe; sampled only in IDLE.
- `Rd`  in  1  read request qualifier.
- `Wr`  in  1  write request qualifier.
- `IOMemSel`  in  1  1 = IO space, 0 = memory space.
- `addr`  in  ADDR_W  memory word address (ignored for IO).
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data; valid with `done`, held until the next successful read.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: the request was malformed and no access occurred.
- `io_out_valid`  out  1  TX FIFO not empty.
- `io_out_data`  out  DATA_W  TX FIFO head word.
- `io_out_ready`  in  1  consumer accepts the head word when high together with `io_out_valid`.
- `io_in_valid`  in  1  external input word available.
- `io_in_data`  in  DATA_W  external input word.
- `io_in_ready`  out  1  pulses high for one cycle to consume `io_in_data`.

## Operation
- States: IDLE, MEM_WAIT, IO_WAIT, RESP.
- IDLE with `req_valid`=1:
  - Latch `Rd`, `Wr`, `IOMemSel`, `addr` and `wdata`.
  - If exactly one of `Rd`/`Wr` is set and `IOMemSel`=0, go to MEM_WAIT and load `cnt` with WAIT_STATES.
  - If exactly one of `Rd`/`Wr` is set and `IOMemSel`=1, go to IO_WAIT.
  - If `Rd` and `Wr` are both set, or neither is set, go to RESP with the error flag set.
- `req_valid` is ignored in every state except IDLE.
- MEM_WAIT:
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access on this edge: a write stores `wdata` at `mem[addr]`; a read loads `rdata` from `mem[addr]`. Then go to RESP.
- IO_WAIT, write: if the FIFO is not full, push `wdata` and go to RESP; otherwise stall.
- IO_WAIT, read: `io_in_ready` = `io_in_valid` (combinational, only in this state). On the handshake, capture `io_in_data` into `rdata` and go to RESP; otherwise stall.
- RESP: `done`=1 and `err`=error flag for exactly one cycle, then go to IDLE.
- TX FIFO:
  - A pop occurs when `io_out_valid` & `io_out_ready`.
  - A push when full is blocked even if a pop happens in the same cycle; the push retries the next cycle.
  - A simultaneous push and pop when not full keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- An error completion or a write completion leaves `rdata` unchanged.
- Memory contents are not reset. FIFO storage is reset to 0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `io_in_ready`, `io_out_valid` = 0; `rdata` = 0; `io_out_data` = 0; FIFO empty; `cnt` = 0.
- Memory latency: `req_valid` accepted at edge 0, so `done` is high in cycle WAIT_STATES+2. With WAIT_STATES=0, `done` is high 2 cycles after accept.
- IO latency: minimum 2 cycles (accept, then IO_WAIT handshake, then RESP). Each stall cycle adds 1.
- Error latency: `done`/`err` are high 1 cycle after accept.
- Back-to-back: the earliest next accept is the cycle after RESP, i.e. `busy` is low for at least one cycle between accesses.
- Reset mid-operation: abandon the access immediately. No `done` is produced. A memory write whose access edge has not occurred is not performed. The FIFO is flushed.
- `io_out_valid` rises in the cycle after the push edge.

## Test plan
- Memory write then read, WAIT_STATES=1: write 0xDEADBEEF to addr 0x12, with `done` 3 cycles after accept and `err`=0. Then read addr 0x12: `rdata`=0xDEADBEEF with `done` 3 cycles after accept, and `busy` high throughout.
- Malformed request: `req_valid` with `Rd`=`Wr`=1 → `done`=`err`=1 one cycle later. `rdata` and memory are unchanged; a subsequent read of the target address returns its old value.
- IO write overflow, FIFO_DEPTH=4, `io_out_ready`=0: 4 writes complete normally. The 5th write stalls with `busy`=1 and no `done`. Raising `io_out_ready` for one cycle pops word 1; the 5th push lands the next cycle and `done` follows. The drained order is words 2,3,4,5.
- IO read stall: `io_in_valid`=0 for 5 cycles → no `done` and `io_in_ready`=0. Assert `io_in_valid` with 0x0000A5A5 → `io_in_ready` is high one cycle, then `done` with `rdata`=0x0000A5A5.
- `req_valid` pulsed while busy: the pulse is ignored, and exactly one `done` is produced for the original request.
- Reset asserted in MEM_WAIT of a write to addr 0x05 (WAIT_STATES=3): all outputs are at their reset values, no `done` is produced, and a read of 0x05 after reset shows the value written before the aborted write.
